// File: rtl/next_queue_ctrl.sv
// next_queue_ctrl: 7-bag upcoming-piece queue sequencer with valid/take head.
// Optional macro NEXT_QUEUE_SEED_LOAD_EN adds seed_load/seed_in ports.

typedef enum logic [2:0] {
  PIECE_I = 3'd0,
  PIECE_O = 3'd1,
  PIECE_T = 3'd2,
  PIECE_J = 3'd3,
  PIECE_L = 3'd4,
  PIECE_S = 3'd5,
  PIECE_Z = 3'd6,
  BLANK   = 3'd7
} tile_type_t;

module next_queue_ctrl #(
  parameter int          QUEUE_DEPTH = 5,
  parameter logic [15:0] SEED        = 16'hACE1,
  localparam int         CW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          take,
`ifdef NEXT_QUEUE_SEED_LOAD_EN
  input  logic          seed_load,
  input  logic [15:0]   seed_in,
`endif
  output logic          next_valid,
  output tile_type_t    next_piece,
  output tile_type_t    pieces_queue [QUEUE_DEPTH],
  output logic [CW-1:0] queue_count
);

  typedef enum logic {
    S_SEARCH = 1'b0,
    S_FULL   = 1'b1
  } state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;
  tile_type_t    r_q     [QUEUE_DEPTH];
  tile_type_t    w_q_nxt [QUEUE_DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_tail;
  logic [6:0]    r_mask;
  logic [6:0]    w_mask_nxt;
  logic [6:0]    w_mask_clr;
  logic [15:0]   r_lfsr;
  logic [15:0]   w_lfsr_nxt;
  logic [15:0]   w_lfsr_step;
  logic [2:0]    r_cand;
  logic [2:0]    w_cand_nxt;
  logic          w_has;
  logic          w_pop_raw;
  logic          w_pop;
  logic          w_room;
  logic          w_search;
  logic          w_commit;

  // Index 7 is not a piece; fold it onto I.
  function automatic logic [2:0] map3(input logic [2:0] v);
    return (v == 3'd7) ? 3'd0 : v;
  endfunction

  assign w_has     = (r_count != '0);
  assign w_pop_raw = take && w_has;
  assign w_pop     = w_pop_raw && !flush;
  assign w_room    = (r_count < DEPTH_C) || w_pop_raw;
  assign w_search  = !flush && (r_state == S_SEARCH) && w_room;
  assign w_commit  = w_search && r_mask[r_cand];
  assign w_tail    = w_pop ? (r_count - 1'b1) : r_count;

  assign w_lfsr_step = {1'b0, r_lfsr[15:1]}
                     ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_mask_clr  = r_mask & ~(7'b1 << r_cand);

  // Next queue contents: flush clears, pop shifts, commit writes the tail.
  always_comb begin
    w_q_nxt = r_q;
    if (flush) begin
      for (int i = 0; i < QUEUE_DEPTH; i++)
        w_q_nxt[i] = BLANK;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < QUEUE_DEPTH - 1; i++)
          w_q_nxt[i] = r_q[i+1];
        w_q_nxt[QUEUE_DEPTH-1] = BLANK;
      end
      for (int i = 0; i < QUEUE_DEPTH; i++)
        if (w_commit && (w_tail == CW'(i)))
          w_q_nxt[i] = tile_type_t'(r_cand);
    end
  end

  // Next count, bag mask, randomizer and FSM state.
  always_comb begin
    w_count_nxt = r_count;
    w_mask_nxt  = r_mask;
    w_lfsr_nxt  = r_lfsr;
    w_cand_nxt  = r_cand;
    w_state_nxt = r_state;
    if (flush) begin
      w_count_nxt = '0;
      w_mask_nxt  = 7'h7F;
      w_state_nxt = S_SEARCH;
    end else begin
      unique case ({w_commit, w_pop})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
      if (w_commit) begin
        w_mask_nxt = (w_mask_clr == 7'h00) ? 7'h7F : w_mask_clr;
        w_lfsr_nxt = w_lfsr_step;
        w_cand_nxt = map3(w_lfsr_step[2:0]);
      end else if (w_search) begin
        w_cand_nxt = (r_cand == 3'd6) ? 3'd0 : r_cand + 3'd1;
      end
      unique case (r_state)
        S_SEARCH: if (!w_room) w_state_nxt = S_FULL;
        S_FULL:   if (w_pop)   w_state_nxt = S_SEARCH;
        default:  w_state_nxt = S_SEARCH;
      endcase
    end
`ifdef NEXT_QUEUE_SEED_LOAD_EN
    if (seed_load) begin
      w_lfsr_nxt = (seed_in == 16'h0000) ? SEED : seed_in;
      w_cand_nxt = map3(w_lfsr_nxt[2:0]);
    end
`endif
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++)
        r_q[i] <= BLANK;
      r_count <= '0;
      r_mask  <= 7'h7F;
      r_lfsr  <= SEED;
      r_cand  <= map3(SEED[2:0]);
      r_state <= S_SEARCH;
    end else begin
      r_q     <= w_q_nxt;
      r_count <= w_count_nxt;
      r_mask  <= w_mask_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_cand  <= w_cand_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign pieces_queue = r_q;
  assign next_piece   = r_q[0];
  assign next_valid   = w_has;
  assign queue_count  = r_count;

endmodule
